acceso_mem: RTL and testbench
=============================

// Module: acceso_mem
// PURPOSE
//  Load/store access unit between the ALU/datapath and the data memory (memoria_datos).
//  Takes outALU as the byte address plus EscrMem/LeerMem/Datain from the datapath.
//  Drives a req/ack handshake to the memory with little-endian byte lanes.
//  Returns a sized, sign/zero-extended load result on Dataout; raises Stall to freeze the PC.
// PARAMETERS
//  ANCHO     32  datapath/memory word width (fixed 32; byte lanes = 4)
//  ADDR_W    10  memory word-address width; mem_addr = outALU[ADDR_W+1:2]
//  TIMEOUT   15  max cycles in ESPERA without mem_ack before bus error (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  LeerMem    in   1       load request (level, held by datapath while Stall=1)
//  EscrMem    in   1       store request (level); wins if both high, read ignored
//  TamMem     in   2       size: 00 byte, 01 half, 10/11 word
//  SignoExt   in   1       1 = sign-extend byte/half loads, 0 = zero-extend
//  outALU     in   32      byte address
//  Datain     in   32      store data (LSB-justified)
//  Dataout    out  32      load result, registered
//  Stall      out  1       freeze PC/pipeline this cycle
//  ErrAlin    out  1       misaligned request this cycle (combinational, IDLE only)
//  ErrBus     out  1       timeout flag, registered, one-cycle pulse in FIN
//  mem_req    out  1       memory request, registered
//  mem_we     out  1       1 = write transaction
//  mem_be     out  4       byte enables, bit i = lane i (bits 8i+7:8i)
//  mem_addr   out  ADDR_W  word address
//  mem_wdata  out  32      write data, lane-replicated
//  mem_rdata  in   32      read data, valid when mem_ack=1
//  mem_ack    in   1       memory completes current request this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; Dataout=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0,
//   mem_wdata=0, ErrBus=0, counter=0. Reset mid-transaction drops mem_req immediately.
//  Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
//  FSM IDLE -> ESPERA -> FIN -> IDLE.
//  IDLE
//   - Accepts an aligned request (LeerMem|EscrMem).
//   - Latches addr/size/sign/data/we, clears the counter, goes to ESPERA.
//   - Stall=1 combinationally in the request cycle.
//   - Misaligned request: ErrAlin=1, Stall=0, no transaction, state stays IDLE.
//  ESPERA
//   - mem_req=1; mem_we/mem_be/mem_addr/mem_wdata held stable. Stall=1.
//   - mem_ack=1: load formats mem_rdata into Dataout at this edge; -> FIN; mem_req low in FIN.
//   - No ack: counter++. Counter==TIMEOUT-1 without ack: drop req, ErrBus=1 in FIN,
//     Dataout=0 for loads, -> FIN.
//  FIN: Stall=0 so the instruction retires. Inputs ignored. -> IDLE next cycle.
//  Latency: request with ack after k cycles in ESPERA -> Stall high for k+1 cycles total.
//  Store lanes
//   - byte: mem_be=1<<a[1:0], wdata={4{Datain[7:0]}}
//   - half: mem_be=a[1]?1100:0011, wdata={2{Datain[15:0]}}
//   - word: mem_be=1111, wdata=Datain
//  Load lanes
//   - Select byte a[1:0] or half a[1], then extend to 32 per SignoExt; word passes through.
//   - mem_be is set as for stores, mem_wdata=0.
//  Dataout holds the last completed load result; stores and errors other than timeout leave it unchanged.
//  mem_ack outside ESPERA is ignored.
// TESTING
//  1. Load word at 0x08, ack 3 cycles after req, rdata=0xDEADBEEF
//     -> mem_addr=2, be=1111; Stall high 4 cycles; Dataout=0xDEADBEEF in FIN.
//  2. Signed byte load at 0x06, rdata=0x0080_0000
//     -> be=0100, Dataout=0xFFFFFF80; repeat with SignoExt=0 -> 0x00000080.
//  3. Half store at 0x0A, Datain=0x1234ABCD
//     -> mem_we=1, be=1100, wdata=0xABCDABCD; Dataout unchanged.
//  4. Word load at 0x01 -> ErrAlin=1, Stall=0, mem_req never asserted.
//  5. Load with no ack -> req high TIMEOUT cycles, then drops; ErrBus pulse; Dataout=0.
//  6. rst_n low mid-ESPERA
//     -> mem_req/Stall drop immediately, Dataout=0; next request runs normally.

Source files
------------

// File: rtl/acceso_mem.sv
// -----------------------------------------------------------------------------
// acceso_mem
//   Load/store access unit between the datapath and the data memory.
//   A request from the datapath (LeerMem/EscrMem, byte address on outALU) is
//   turned into one req/ack transaction on the memory port with little-endian
//   byte lanes. Loads come back sized and sign/zero-extended on Dataout.
//   Stall freezes the PC for as long as the access is outstanding.
//
//   Handshake: mem_req is raised on the cycle after an accepted request and
//   held, together with mem_we/mem_be/mem_addr/mem_wdata, until the memory
//   answers with mem_ack=1 in the same cycle (transfer completes on that edge)
//   or until TIMEOUT cycles pass without ack (bus error). mem_ack seen while
//   mem_req is low is ignored.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   LeerMem, EscrMem      load / store request levels (store wins if both)
//   TamMem                size: 00 byte, 01 half, 1x word
//   SignoExt              sign-extend byte/half loads when 1
//   outALU                byte address
//   Datain                store data, LSB-justified
//   Dataout               last completed load result (registered)
//   Stall                 freeze pipeline this cycle
//   ErrAlin               misaligned request in IDLE (combinational)
//   ErrBus                one-cycle timeout pulse (registered, FIN only)
//   mem_req/we/be/addr/wdata   memory request side (registered)
//   mem_rdata, mem_ack    memory response side
// -----------------------------------------------------------------------------
module acceso_mem #(
  parameter int ANCHO   = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LeerMem,
  input  logic              EscrMem,
  input  logic [1:0]        TamMem,
  input  logic              SignoExt,
  input  logic [ANCHO-1:0]  outALU,
  input  logic [ANCHO-1:0]  Datain,
  output logic [ANCHO-1:0]  Dataout,
  output logic              Stall,
  output logic              ErrAlin,
  output logic              ErrBus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ANCHO-1:0]  mem_wdata,
  input  logic [ANCHO-1:0]  mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         tam_q, tam_d;
  logic [1:0]         off_q, off_d;
  logic               sext_q, sext_d;
  logic [ANCHO-1:0]   dout_q, dout_d;
  logic               err_bus_q, err_bus_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ANCHO-1:0]   mem_wdata_q, mem_wdata_d;

  logic               req_any;
  logic               misal;
  logic               in_idle;
  logic [3:0]         be_new;
  logic [ANCHO-1:0]   wdata_new;
  logic [ANCHO-1:0]   rd_shift;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [ANCHO-1:0]   load_val;

  // Address bits above the memory window do not take part in the access.
  logic unused_addr_hi;
  assign unused_addr_hi = ^outALU[ANCHO-1:ADDR_W+2];

  always_comb begin
    req_any  = LeerMem | EscrMem;
    misal    = ((TamMem == 2'b01) & outALU[0]) | (TamMem[1] & (|outALU[1:0]));
    in_idle  = (state_q == IDLE);
    ErrAlin  = in_idle & req_any & misal;
    Stall    = (in_idle & req_any & ~misal) | (state_q == ESPERA);

    // Store lane placement for the incoming request.
    be_new    = 4'b1111;
    wdata_new = Datain;
    case (TamMem)
      2'b00: begin
        be_new    = 4'b0001 << outALU[1:0];
        wdata_new = {4{Datain[7:0]}};
      end
      2'b01: begin
        be_new    = outALU[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{Datain[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = Datain;
      end
    endcase

    // Load formatting uses the latched offset/size/sign of the access.
    rd_shift = mem_rdata >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (tam_q)
      2'b00:   load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{sext_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase

    state_d     = state_q;
    cnt_d       = cnt_q;
    tam_d       = tam_q;
    off_d       = off_q;
    sext_d      = sext_q;
    dout_d      = dout_q;
    err_bus_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_any && !misal) begin
          state_d     = ESPERA;
          cnt_d       = '0;
          tam_d       = TamMem;
          off_d       = outALU[1:0];
          sext_d      = SignoExt;
          mem_req_d   = 1'b1;
          mem_we_d    = EscrMem;
          mem_be_d    = be_new;
          mem_addr_d  = outALU[ADDR_W+1:2];
          mem_wdata_d = EscrMem ? wdata_new : '0;
        end
      end
      ESPERA: begin
        if (mem_ack) begin
          state_d   = FIN;
          mem_req_d = 1'b0;
          if (!mem_we_q) dout_d = load_val;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Memory never answered: abandon the access and flag it.
          state_d   = FIN;
          mem_req_d = 1'b0;
          err_bus_d = 1'b1;
          if (!mem_we_q) dout_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tam_q       <= 2'b00;
      off_q       <= 2'b00;
      sext_q      <= 1'b0;
      dout_q      <= '0;
      err_bus_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tam_q       <= tam_d;
      off_q       <= off_d;
      sext_q      <= sext_d;
      dout_q      <= dout_d;
      err_bus_q   <= err_bus_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign Dataout   = dout_q;
  assign ErrBus    = err_bus_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_acceso_mem.sv
// -----------------------------------------------------------------------------
// tb_acceso_mem
//   Bench for acceso_mem. The driver issues datapath requests and plays the
//   memory (ack after a chosen number of cycles, or never). Expected memory
//   requests and expected completions are computed from the access rules with
//   plain arithmetic and queued; a monitor pops and compares them when the DUT
//   raises mem_req and when Stall falls at the end of an access.
// -----------------------------------------------------------------------------
module tb_acceso_mem;

  localparam int TIMEOUT = 15;
  localparam int ADDR_W  = 10;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              LeerMem   = 1'b0;
  logic              EscrMem   = 1'b0;
  logic [1:0]        TamMem    = 2'b00;
  logic              SignoExt  = 1'b0;
  logic [31:0]       outALU    = '0;
  logic [31:0]       Datain    = '0;
  logic [31:0]       Dataout;
  logic              Stall;
  logic              ErrAlin;
  logic              ErrBus;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack   = 1'b0;

  acceso_mem #(.ANCHO(32), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .LeerMem(LeerMem), .EscrMem(EscrMem),
    .TamMem(TamMem), .SignoExt(SignoExt), .outALU(outALU), .Datain(Datain),
    .Dataout(Dataout), .Stall(Stall), .ErrAlin(ErrAlin), .ErrBus(ErrBus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        err;
    logic [7:0]  stall_len;
    logic [7:0]  req_len;
  } fin_t;

  req_t        exp_req_q[$];
  fin_t        exp_fin_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [1:0] tam);
    return (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int off);
    int m;
    m = ((1 << sz) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] din);
    if (sz == 1) return (din & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (din & 32'hFFFF) * 32'h0001_0001;
    return din;
  endfunction

  function automatic logic [31:0] model_load(input int sz, input int off, input logic sx,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    LeerMem = 1'b0; EscrMem = 1'b0; TamMem = 2'b00; SignoExt = 1'b0;
    outALU  = '0;   Datain  = '0;   mem_ack = 1'b0;
  endtask

  // One datapath access. delay = ESPERA cycle in which ack arrives (>=1).
  task automatic do_txn(input logic we, input logic rd, input logic [1:0] tam,
                        input logic sx, input logic [31:0] a, input logic [31:0] din,
                        input logic [31:0] rdata, input int delay, input logic noack);
    int   sz;
    int   off;
    int   wait_cycles;
    logic mis;
    req_t r;
    fin_t f;
    sz  = size_of(tam);
    off = int'(a[1:0]);
    mis = (off % sz) != 0;

    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    EscrMem = we; LeerMem = rd; TamMem = tam; SignoExt = sx; outALU = a; Datain = din;
    mem_ack = 1'b0;

    if (mis) begin
      @(negedge clk);
      check("err_alin", 32'(ErrAlin), 32'd1);
      check("stall_misaligned", 32'(Stall), 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      return;
    end

    r.we    = we;
    r.be    = model_be(sz, off);
    r.addr  = a[ADDR_W+1:2];
    r.wdata = we ? model_wdata(sz, din) : 32'd0;
    exp_req_q.push_back(r);

    f.err       = noack;
    f.stall_len = 8'(1 + (noack ? TIMEOUT : delay));
    f.req_len   = 8'(noack ? TIMEOUT : delay);
    if (we)         f.dout = last_dout;
    else if (noack) f.dout = 32'd0;
    else            f.dout = model_load(sz, off, sx, rdata);
    last_dout = f.dout;
    exp_fin_q.push_back(f);

    @(negedge clk);
    check("err_alin_aligned", 32'(ErrAlin), 32'd0);
    check("stall_request_cycle", 32'(Stall), 32'd1);

    @(posedge clk); #1;
    wait_cycles = noack ? TIMEOUT : delay;
    for (int i = 1; i <= wait_cycles; i++) begin
      mem_ack   = (!noack && i == delay);
      mem_rdata = mem_ack ? rdata : $urandom;
      @(posedge clk); #1;
    end
    // FIN: inputs are ignored, so throw garbage (including a stray ack) at it.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    LeerMem   = 1'b0;
    EscrMem   = 1'b0;
    outALU    = $urandom;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Start a load and pull reset while it waits for the memory.
  task automatic reset_mid_txn();
    req_t r;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    LeerMem = 1'b1; TamMem = 2'b10; outALU = 32'h0000_0020;
    r.we = 1'b0; r.be = 4'b1111; r.addr = 10'd8; r.wdata = 32'd0;
    exp_req_q.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    LeerMem = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(Stall), 32'd0);
    check("rst_mid_dout", Dataout, 32'd0);
    last_dout = 32'd0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    clear_inputs();
  endtask

  // ---------------- monitor ----------------
  logic prev_stall = 1'b0;
  logic prev_req   = 1'b0;
  int   stall_len  = 0;
  int   req_len    = 0;

  always @(negedge clk) begin
    req_t r;
    fin_t f;
    logic fin_now;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_req   = 1'b0;
      stall_len  = 0;
      req_len    = 0;
    end else begin
      fin_now = prev_stall && !Stall;
      if (mem_req && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          r = exp_req_q.pop_front();
          check("req_we", 32'(mem_we), 32'(r.we));
          check("req_be", 32'(mem_be), 32'(r.be));
          check("req_addr", 32'(mem_addr), 32'(r.addr));
          check("req_wdata", mem_wdata, r.wdata);
        end
      end
      if (fin_now) begin
        if (exp_fin_q.size() == 0) begin
          check("unexpected_fin", 32'd1, 32'd0);
        end else begin
          f = exp_fin_q.pop_front();
          check("fin_dataout", Dataout, f.dout);
          check("fin_errbus", 32'(ErrBus), 32'(f.err));
          check("fin_req_low", 32'(mem_req), 32'd0);
          check("stall_cycles", 32'(stall_len), 32'(f.stall_len));
          check("req_cycles", 32'(req_len), 32'(f.req_len));
        end
        stall_len = 0;
        req_len   = 0;
      end else begin
        check("errbus_quiet", 32'(ErrBus), 32'd0);
      end
      if (Stall)   stall_len++;
      if (mem_req) req_len++;
      prev_stall = Stall;
      prev_req   = mem_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        r_we, r_rd, r_sx, r_noack;
    logic [1:0]  r_tam;
    logic [31:0] r_a;
    int          r_delay;

    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_dataout", Dataout, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_errbus", 32'(ErrBus), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);

    // Directed cases.
    do_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, 3, 1'b0);
    do_txn(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0006, 32'd0, 32'h0080_0000, 2, 1'b0);
    do_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'd0, 32'h0080_0000, 1, 1'b0);
    do_txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h1234_ABCD, 32'h5555_5555, 2, 1'b0);
    do_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'd0, 32'd0, 1, 1'b0);
    do_txn(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0003, 32'd0, 32'd0, 1, 1'b0);
    do_txn(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0012, 32'd0, 32'h8001_7FFF, 4, 1'b0);
    do_txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0FFF, 32'h0000_00A5, 32'h0, 1, 1'b0);
    do_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'h0, 1, 1'b1);
    do_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
    reset_mid_txn();
    do_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'd0, 32'hF00D_1234, 2, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 150; n++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_rd  = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
      r_tam = 2'($urandom_range(0, 3));
      r_sx  = 1'($urandom_range(0, 1));
      r_a   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_tam == 2'b01) r_a[0] = 1'b0;
        if (r_tam[1])       r_a[1:0] = 2'b00;
      end
      r_delay = $urandom_range(1, 5);
      r_noack = ($urandom_range(0, 9) == 0);
      do_txn(r_we, r_rd, r_tam, r_sx, r_a, $urandom, $urandom, r_delay, r_noack);
    end

    repeat (5) @(negedge clk);
    check("exp_req_left", 32'(exp_req_q.size()), 32'd0);
    check("exp_fin_left", 32'(exp_fin_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
